// File: rtl/scan_test_ctrl.sv
// rtl/scan_test_ctrl.sv - scan test sequencer: shift a pattern in, run N functional clocks, shift out and compare
module scan_test_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] pattern,
    input  logic [3:0] capture_cycles,
    input  logic [7:0] expected,
    input  logic       scan_out,
    output logic       scan_en,
    output logic       scan_in,
    output logic       enable,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] result
);

    typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] n_q, n_nxt;
    logic [7:0] exp_q, exp_nxt;
    logic [7:0] sh_q, sh_nxt;
    logic [7:0] result_nxt;
    logic       scan_en_nxt, scan_in_nxt, enable_nxt, busy_nxt, done_nxt, pass_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            n_q     <= 4'd0;
            exp_q   <= 8'd0;
            sh_q    <= 8'd0;
            scan_en <= 1'b0;
            scan_in <= 1'b0;
            enable  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            result  <= 8'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            n_q     <= n_nxt;
            exp_q   <= exp_nxt;
            sh_q    <= sh_nxt;
            scan_en <= scan_en_nxt;
            scan_in <= scan_in_nxt;
            enable  <= enable_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            pass    <= pass_nxt;
            result  <= result_nxt;
        end
    end

    // Outputs are computed for the state being entered so they come straight from flops.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        n_nxt       = n_q;
        exp_nxt     = exp_q;
        sh_nxt      = sh_q;
        result_nxt  = result;
        pass_nxt    = pass;
        scan_en_nxt = 1'b0;
        scan_in_nxt = 1'b0;
        enable_nxt  = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = SHIFT_IN;
                    cnt_nxt     = 4'd0;
                    n_nxt       = capture_cycles;
                    exp_nxt     = expected;
                    sh_nxt      = {pattern[6:0], 1'b0};
                    scan_in_nxt = pattern[7];
                    scan_en_nxt = 1'b1;
                    busy_nxt    = 1'b1;
                    result_nxt  = 8'd0;
                    pass_nxt    = 1'b0;
                end
            end
            SHIFT_IN: begin
                busy_nxt = 1'b1;
                if (cnt == 4'd7) begin
                    cnt_nxt = 4'd0;
                    if (n_q != 4'd0) begin
                        state_nxt  = CAPTURE;
                        enable_nxt = 1'b1;
                    end else begin
                        state_nxt   = SHIFT_OUT;
                        scan_en_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt     = cnt + 4'd1;
                    scan_en_nxt = 1'b1;
                    scan_in_nxt = sh_q[7];
                    sh_nxt      = {sh_q[6:0], 1'b0};
                end
            end
            CAPTURE: begin
                busy_nxt = 1'b1;
                if (cnt == n_q - 4'd1) begin
                    state_nxt   = SHIFT_OUT;
                    cnt_nxt     = 4'd0;
                    scan_en_nxt = 1'b1;
                end else begin
                    cnt_nxt    = cnt + 4'd1;
                    enable_nxt = 1'b1;
                end
            end
            SHIFT_OUT: begin
                result_nxt = {result[6:0], scan_out};
                if (cnt == 4'd7) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    pass_nxt  = ({result[6:0], scan_out} == exp_q);
                end else begin
                    cnt_nxt     = cnt + 4'd1;
                    scan_en_nxt = 1'b1;
                    busy_nxt    = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort drops everything except the last reported result.
        if (abort) begin
            state_nxt   = IDLE;
            result_nxt  = result;
            pass_nxt    = pass;
            scan_en_nxt = 1'b0;
            scan_in_nxt = 1'b0;
            enable_nxt  = 1'b0;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b0;
        end
    end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// tb/tb_scan_test_ctrl.sv - bench with counter_scan chain model and timeline-based reference model
module tb_scan_test_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] pattern = 8'd0;
    logic [3:0] capture_cycles = 4'd0;
    logic [7:0] expected = 8'd0;
    logic       scan_out;
    logic       scan_en, scan_in, enable, busy, done, pass;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;
    int ecount = 0;

    scan_test_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pattern(pattern), .capture_cycles(capture_cycles), .expected(expected),
        .scan_out(scan_out), .scan_en(scan_en), .scan_in(scan_in), .enable(enable),
        .busy(busy), .done(done), .pass(pass), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecount++;

    // counter_scan stand-in: shift in shift mode, count when enabled
    logic [7:0] chain = 8'd0;
    assign scan_out = chain[7];
    always @(posedge clk) begin
        if (scan_en) chain <= {chain[6:0], scan_in};
        else if (enable) chain <= chain + 8'd1;
    end

    // Reference: position p = edges since the accepting edge E0
    bit         m_act = 0;
    int         m_p = 0;
    logic [7:0] m_pat = 0;
    int         m_n = 0;
    logic [7:0] m_exp = 0;
    logic [7:0] m_res = 0;
    bit         m_pass = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act = 0; m_res = 0; m_pass = 0;
        end else if (abort) begin
            m_act = 0;
        end else if (m_act) begin
            if (m_p == 16 + m_n) m_act = 0;
            else begin
                m_p++;
                if (m_p == 16 + m_n) begin
                    m_res  = 8'((int'(m_pat) + m_n) % 256);
                    m_pass = (m_res == m_exp);
                end
            end
        end else if (start) begin
            m_act = 1; m_p = 0; m_pat = pattern; m_n = int'(capture_cycles);
            m_exp = expected; m_res = 0; m_pass = 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit e_busy, e_done, e_sen, e_en, e_sin;
        e_busy = m_act && (m_p <= 15 + m_n);
        e_done = m_act && (m_p == 16 + m_n);
        e_sen  = m_act && (m_p < 8 || (m_p >= 8 + m_n && m_p < 16 + m_n));
        e_en   = m_act && (m_p >= 8 && m_p < 8 + m_n);
        e_sin  = (m_act && m_p < 8) ? m_pat[7 - m_p] : 1'b0;
        chk("cmp_busy", int'(busy), int'(e_busy));
        chk("cmp_done", int'(done), int'(e_done));
        chk("cmp_scan_en", int'(scan_en), int'(e_sen));
        chk("cmp_enable", int'(enable), int'(e_en));
        chk("cmp_scan_in", int'(scan_in), int'(e_sin));
        if (!e_busy) begin
            chk("cmp_result", int'(result), int'(m_res));
            chk("cmp_pass", int'(pass), int'(m_pass));
        end
    end

    task automatic run_seq(input logic [7:0] pat, input logic [3:0] n, input logic [7:0] ex,
                           output int done_at, output logic [7:0] sin);
        int e0;
        done_at = -1;
        sin = 8'd0;
        @(posedge clk); #2;
        pattern = pat; capture_cycles = n; expected = ex; start = 1'b1;
        @(posedge clk); #1 e0 = ecount;
        #1 start = 1'b0;
        pattern = ~pat; capture_cycles = ~n; expected = ~ex;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i < 8) sin = {sin[6:0], scan_in};
            if (done) begin
                done_at = ecount - e0;
                break;
            end
        end
    endtask

    int         dat;
    logic [7:0] sbits;
    int         dcount;

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("reset_busy", int'(busy), 0);
        chk("reset_result", int'(result), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        run_seq(8'h00, 4'd5, 8'h05, dat, sbits);
        chk("p00_done_edge", dat, 21);
        chk("p00_result", int'(result), 8'h05);
        chk("p00_pass", int'(pass), 1);

        run_seq(8'hB3, 4'd0, 8'hB3, dat, sbits);
        chk("pB3_done_edge", dat, 16);
        chk("pB3_scan_in_seq", int'(sbits), 8'hB3);
        chk("pB3_result", int'(result), 8'hB3);
        chk("pB3_pass", int'(pass), 1);

        run_seq(8'hFE, 4'd3, 8'h01, dat, sbits);
        chk("pFE_done_edge", dat, 19);
        chk("pFE_result", int'(result), 8'h01);
        chk("pFE_pass", int'(pass), 1);

        run_seq(8'hFE, 4'd3, 8'h02, dat, sbits);
        chk("pFE2_result", int'(result), 8'h01);
        chk("pFE2_pass", int'(pass), 0);
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        chk("start_in_done_ignored", int'(busy), 0);

        // start and abort together in IDLE
        @(posedge clk); #2 start = 1'b1; abort = 1'b1;
        @(posedge clk); #2 start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", int'(busy), 0);

        // abort in the 4th SHIFT_IN cycle with start held high
        @(posedge clk); #2 pattern = 8'h5A; capture_cycles = 4'd2; expected = 8'h5C; start = 1'b1;
        repeat (4) @(posedge clk);
        #2 abort = 1'b1; start = 1'b0;
        @(posedge clk); #2 abort = 1'b0;
        chk("abort_scan_en", int'(scan_en), 0);
        chk("abort_busy", int'(busy), 0);
        dcount = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);

        run_seq(8'h5A, 4'd2, 8'h5C, dat, sbits);
        chk("p5A_done_edge", dat, 18);
        chk("p5A_result", int'(result), 8'h5C);
        chk("p5A_pass", int'(pass), 1);

        // reset during CAPTURE, between clock edges
        @(posedge clk); #2 pattern = 8'h20; capture_cycles = 4'd10; expected = 8'h2A; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        dcount = 0;
        while (!enable && dcount < 30) begin
            @(negedge clk);
            dcount++;
        end
        chk("reach_capture", int'(enable), 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_outputs",
            int'({scan_en, scan_in, enable, busy, done, pass}), 0);
        chk("rst_async_result", int'(result), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        run_seq(8'h10, 4'd1, 8'h11, dat, sbits);
        chk("p10_done_edge", dat, 17);
        chk("p10_result", int'(result), 8'h11);
        chk("p10_pass", int'(pass), 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
